// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and sweep classifier for the 4x4 keypad scanner
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  typedef enum logic [1:0] {DRIVE, SAMPLE, EVAL} state_t;
  typedef logic [4:0] cls_t;
  localparam cls_t NONE = 5'h10;
  localparam logic [3:0] KEY_MAP [NUM_COLS][NUM_ROWS] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };
  // A sweep is a key only when exactly one of the 16 active-low samples is low;
  // bit c*NUM_ROWS+r holds row r seen while column c was driven.
  function automatic cls_t classify(input logic [NUM_COLS*NUM_ROWS-1:0] s);
    logic [4:0] zeros;
    logic [3:0] code;
    zeros = '0;
    code = '0;
    for (int c = 0; c < NUM_COLS; c++)
      for (int r = 0; r < NUM_ROWS; r++)
        if (!s[c*NUM_ROWS+r]) begin
          zeros = zeros + 5'd1;
          code = KEY_MAP[c][r];
        end
    return zeros == 5'd1 ? {1'b0, code} : NONE;
  endfunction
endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: W-bit two-flop synchronizer, resets to all-ones (idle rows)
// Ports: clk, reset (async, active high), d (async input), q (synchronized output).
module keypad_row_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m <= '1;
      q <= '1;
    end else begin
      m <= d;
      q <= m;
    end
endmodule

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: 4x4 keypad column scanner with sweep classification and debounce
// Ports: clk, reset (async, active high), row[3:0] (active-low rows in),
//   col[3:0] (one-hot active-low columns out), dec[3:0] (last accepted key),
//   key_down (accepted key held), key_valid (one-cycle pulse per accepted press).
// Build option: define KEYPAD_DEBOUNCE_EN to require DEBOUNCE_SWEEPS identical sweeps;
//   without it every sweep is accepted or released immediately.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS      = 100000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dec,
  output logic       key_down,
  output logic       key_valid
);
  localparam int TW = $clog2(SCAN_TICKS);
  if (SCAN_TICKS < 4 || DEBOUNCE_SWEEPS < 1) begin : g_param_check
    $error("keypad_scan_decoder: SCAN_TICKS must be >= 4 and DEBOUNCE_SWEEPS >= 1");
  end
  state_t state;
  logic [1:0] idx, idx_n;
  logic [TW-1:0] tick;
  logic [3:0] row_s;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] sweep_rows;
  cls_t cls;
  logic last_tick, hit, accept, rel;
  keypad_row_sync #(.W(NUM_ROWS)) u_sync (.clk(clk), .reset(reset), .d(row), .q(row_s));
  assign cls = classify(sweep_rows);
  assign last_tick = tick == TW'(SCAN_TICKS - 1);
  // idx wraps 3->0 on the last SAMPLE, so column 0 is already driven during EVAL
  assign idx_n = state == SAMPLE ? idx + 2'd1 : state == EVAL ? 2'd0 : idx;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
  cls_t cand;
  logic [CW-1:0] cnt, cnt_n;
  assign cnt_n = cls != cand ? CW'(1) : cnt == CW'(DEBOUNCE_SWEEPS) ? cnt : cnt + 1'b1;
  assign hit = cnt_n == CW'(DEBOUNCE_SWEEPS);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cand <= NONE;
      cnt <= '0;
    end else if (state == EVAL) begin
      cand <= cls;
      cnt <= cnt_n;
    end
`else
  assign hit = 1'b1;
`endif
  // key_down blocks a roll-over to another key until a release has been accepted
  assign accept = state == EVAL && hit && cls != NONE && !key_down;
  assign rel = state == EVAL && hit && cls == NONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= DRIVE;
      idx <= '0;
      tick <= '0;
      sweep_rows <= '1;
      col <= 4'b1111;
      dec <= 4'h0;
      key_down <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      col <= ~(4'b0001 << idx_n);
      idx <= idx_n;
      key_valid <= accept;
      if (accept) begin
        dec <= cls[3:0];
        key_down <= 1'b1;
      end else if (rel)
        key_down <= 1'b0;
      case (state)
        DRIVE: begin
          tick <= last_tick ? '0 : tick + 1'b1;
          state <= last_tick ? SAMPLE : DRIVE;
        end
        SAMPLE: begin
          sweep_rows[idx] <= row_s;
          state <= idx == 2'd3 ? EVAL : DRIVE;
        end
        default: state <= DRIVE;
      endcase
    end
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder: sweep-level model of the keypad decoder checked every cycle
module tb_keypad_scan_decoder;
  localparam int ST = 8;
  localparam int SP = 4 * (ST + 1) + 1;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DB = 3;
  localparam bit EN = 1;
`else
  localparam int DB = 1;
  localparam bit EN = 0;
`endif
  logic clk = 0;
  logic reset = 1;
  logic [3:0] row, col, dec;
  logic key_down, key_valid;
  int cyc = 0;
  int total = 0, passed = 0;
  int pulses = 0, first_kv = -1;
  logic [15:0] pat [64];
  int npat = 0;
  int cls_h [64];
  logic [3:0] exp_dec = 0;
  logic exp_kd = 0, exp_kv = 0;
  keypad_scan_decoder #(.SCAN_TICKS(ST), .DEBOUNCE_SWEEPS(3)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .dec(dec),
    .key_down(key_down), .key_valid(key_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] kcode(int c, int r);
    logic [3:0] t [4][4];
    t = '{'{4'h1, 4'h4, 4'h7, 4'h0}, '{4'h2, 4'h5, 4'h8, 4'hF},
          '{4'h3, 4'h6, 4'h9, 4'hE}, '{4'hA, 4'hB, 4'hC, 4'hD}};
    return t[c][r];
  endfunction
  function automatic logic [15:0] k(int code);
    return 16'(1) << code;
  endfunction
  function automatic logic [15:0] mask_of(int sw);
    return sw < npat ? pat[sw] : 16'h0;
  endfunction
  // 16 = no key; a single pressed key is the only way to get exactly one low sample
  function automatic int cls_of(logic [15:0] m);
    int c;
    c = 16;
    if ($countones(m) == 1)
      for (int i = 0; i < 16; i++) if (m[i]) c = i;
    return c;
  endfunction
  function automatic logic [3:0] exp_col();
    int p;
    p = cyc % SP;
    if (reset || cyc == 0) return 4'hF;
    if (p == SP - 1) return 4'hE;
    return ~(4'b0001 << (p / (ST + 1)));
  endfunction
  always_comb begin
    logic [15:0] m;
    m = (cyc / SP < npat) ? pat[cyc / SP] : 16'h0;
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && m[kcode(c, r)]) row[r] = 1'b0;
  end
  always @(posedge clk or posedge reset)
    if (reset) begin
      cyc <= 0;
      exp_dec = 0;
      exp_kd = 0;
      exp_kv = 0;
    end else begin
      exp_kv = 0;
      if (cyc % SP == SP - 1) begin
        int sw;
        bit stable;
        sw = cyc / SP;
        cls_h[sw] = cls_of(mask_of(sw));
        stable = sw + 1 >= DB;
        for (int i = 0; i < DB; i++)
          if (sw - i >= 0 && cls_h[sw - i] != cls_h[sw]) stable = 0;
        if (stable && cls_h[sw] != 16 && !exp_kd) begin
          exp_kv = 1;
          exp_kd = 1;
          exp_dec = 4'(cls_h[sw]);
        end else if (stable && cls_h[sw] == 16)
          exp_kd = 0;
      end
      cyc <= cyc + 1;
    end
  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask
  always @(negedge clk) begin
    if (reset) begin
      pulses = 0;
      first_kv = -1;
    end else if (key_valid) begin
      pulses++;
      if (first_kv < 0) first_kv = cyc;
    end
    chk("col", int'(col), int'(exp_col()));
    chk("dec", int'(dec), int'(exp_dec));
    chk("key_down", int'(key_down), int'(exp_kd));
    chk("key_valid", int'(key_valid), int'(exp_kv));
  end
  task automatic setp(int i, int n, logic [15:0] m);
    for (int j = i; j < i + n; j++) pat[j] = m;
    if (i + n > npat) npat = i + n;
  endtask
  task automatic start();
    @(posedge clk);
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic wait_sweeps(int n);
    repeat (SP * n) @(posedge clk);
    #2;
  endtask
  initial begin
    npat = 0;
    setp(0, 5, k(5));
    start();
    wait_sweeps(8);
    chk("press5_pulses", pulses, 1);
    chk("press5_first", first_kv, EN ? 111 : 37);
    chk("press5_dec", int'(dec), 5);
    chk("press5_released", int'(key_down), 0);
    npat = 0;
    setp(0, 1, k(9));
    setp(1, 1, 16'h0);
    setp(2, 3, k(9));
    start();
    wait_sweeps(6);
    chk("bounce_pulses", pulses, EN ? 1 : 2);
    chk("bounce_first", first_kv, EN ? 185 : 37);
    chk("bounce_dec", int'(dec), 9);
    npat = 0;
    setp(0, 3, k(7));
    setp(3, 3, 16'h0);
    setp(6, 6, k(1) | k(10));
    start();
    wait_sweeps(14);
    chk("ghost_pulses", pulses, 1);
    chk("ghost_dec", int'(dec), 7);
    npat = 0;
    setp(0, 4, k(2));
    setp(4, 4, k(15));
    setp(8, 3, 16'h0);
    setp(11, 4, k(15));
    start();
    wait_sweeps(8);
    chk("roll_hold_dec", int'(dec), 2);
    chk("roll_hold_down", int'(key_down), 1);
    wait_sweeps(7);
    chk("roll_dec", int'(dec), 15);
    chk("roll_pulses", pulses, 2);
    npat = 0;
    setp(0, 1, k(12));
    start();
    wait_sweeps(5);
    chk("single_pulses", pulses, EN ? 0 : 1);
    chk("single_dec", int'(dec), EN ? 0 : 12);
    npat = 0;
    setp(0, 6, k(3));
    start();
    wait_sweeps(3);
    chk("pre_reset_dec", int'(dec), 3);
    repeat (18) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("async_col", int'(col), 15);
    chk("async_dec", int'(dec), 0);
    chk("async_down", int'(key_down), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1;
    chk("post_reset_col", int'(col), 14);
    repeat (SP * 4 - 1) @(posedge clk);
    #1;
    chk("post_reset_dec", int'(dec), 3);
    chk("post_reset_pulses", pulses, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/keypad_scan_decoder.md
# keypad_scan_decoder

Scans the 4x4 Pmod keypad and debounces the result. Drives one column low at a time and samples the four row inputs. Resolves the single pressed key into a 4-bit hex code. That code feeds the `dec` input of the seven-segment control stage directly downstream.

## Interface
- `SCAN_TICKS`, default 100000, clock cycles each column is driven (1 ms at 100 MHz); minimum 4.
- `DEBOUNCE_SWEEPS`, default 4, consecutive identical sweeps required to accept a press or a release; minimum 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `row`  in  4  keypad rows, active low; `row[0]` is the top row. Asynchronous to `clk`.
- `col`  out  4  keypad columns, one-hot active low; `col[0]` is the leftmost column.
- `dec`  out  4  hex code of the last accepted key; held until the next accepted press.
- `key_down`  out  1  high while an accepted key is held.
- `key_valid`  out  1  single-cycle pulse when a new press is accepted.

## Operation
- Key map, indexed `[col][row top→bottom]`:
  - col0 = 1,4,7,0
  - col1 = 2,5,8,F
  - col2 = 3,6,9,E
  - col3 = A,B,C,D
- `row` passes through a 2-flop synchronizer before any use.
- FSM states and transitions:
  - `DRIVE`: assert `col` = ~(1<<idx) and count to SCAN_TICKS-1.
  - `SAMPLE` (1 cycle): latch synced rows into `sweep_rows[idx]`. Increment idx. Go to `DRIVE`, or to `EVAL` after idx 3.
  - `EVAL` (1 cycle): classify the sweep, update the debounce logic, idx←0, return to `DRIVE`.
- Sweep classification:
  - exactly one zero bit over all 16 samples → key code;
  - zero zeros → none;
  - two or more zeros → none (ghost/multi-key reject, not a press).
- Debounce:
  - `cand`/`cnt` track the classification of consecutive sweeps; `cnt` saturates at DEBOUNCE_SWEEPS.
  - A change of classification reloads `cnt`=1.
  - When `cnt` reaches DEBOUNCE_SWEEPS with `cand`=key and `key_down`=0: set `dec`←code, `key_down`←1, pulse `key_valid`.
  - When `cnt` reaches DEBOUNCE_SWEEPS with `cand`=none: clear `key_down`.
  - A different key while `key_down`=1 is not accepted until a release has been accepted first.
- Reset values (all asynchronous):
  - `col`=4'b1111, `dec`=4'h0, `key_down`=0, `key_valid`=0;
  - FSM=`DRIVE`, idx=0, counters=0, `cand`=none.
- Reset mid-sweep discards partial samples. The first sweep after reset starts at column 0.

## Timing
- Column drive window: SCAN_TICKS cycles.
- Sample point: the `SAMPLE` cycle, after the synchronizer delay. SCAN_TICKS≥4 guarantees settled rows.
- Sweep period: 4·(SCAN_TICKS+1)+1 cycles.
- `col` is 4'b1111 only during reset. During `SAMPLE` the current column stays driven; during `EVAL` column 0 is driven.
- Press latency: `key_valid` rises the cycle after the `EVAL` of the DEBOUNCE_SWEEPS-th matching sweep. `dec` updates in the same cycle.
- `dec` is stable between accepts, so the downstream stage needs no handshake.
- `key_valid` never asserts on two consecutive cycles. At most one pulse per accepted press.

## Configuration
- `KEYPAD_DEBOUNCE_EN` defined: debounce exactly as described above.
- Undefined:
  - DEBOUNCE_SWEEPS is ignored and treated as 1;
  - every `EVAL` with a single key and `key_down`=0 accepts immediately;
  - every `EVAL` with none releases immediately;
  - `cand`/`cnt` registers are omitted.

## Structure
- Package `keypad_pkg`:
  - FSM state enum (`DRIVE`, `SAMPLE`, `EVAL`);
  - `NUM_COLS`=4, `NUM_ROWS`=4;
  - key-map constant array;
  - NONE classification encoding.
- Sub-module `keypad_row_sync`: a parameterised-width 2-flop synchronizer, reset to all-ones (idle rows).

## Test plan
All scenarios use SCAN_TICKS=8 and DEBOUNCE_SWEEPS=3, so one sweep = 37 cycles. A behavioural keypad model pulls a row low whenever its column is driven.

- Reset: assert `reset` mid-sweep → `col`=4'b1111, `dec`=0, `key_down`=0 asynchronously. After release, `col`=4'b1110 within 1 cycle.
- Press '5' (col1,row1) for 5 sweeps → one `key_valid` pulse after the 3rd sweep's `EVAL`, `dec`=4'h5, `key_down`=1.
- Bounce: '9' present on sweeps 1,3,4,5 only → no pulse before sweep 5's `EVAL`, then `dec`=4'h9.
- Ghost: press '1' and 'A' together for 6 sweeps → no `key_valid`, `dec` unchanged.
- Roll-over: hold '2', then switch to 'F' without release → `dec` stays 4'h2. After release ≥3 sweeps and 'F' held ≥3 sweeps → `dec`=4'hF.
- With `KEYPAD_DEBOUNCE_EN` undefined: press 'C' for 1 sweep → `key_valid` after the first `EVAL`, `dec`=4'hC.
